// File: rtl/vending_machine_multi_if.sv
// ---------------------------------------------------------------------------
// vending_machine_multi_if
// Bundles the coin-acceptor / keypad inputs and the dispenser / hopper
// outputs of the multi-product vending controller.
//   master : drives coin, sel, vend_req, cancel, restock; observes the rest
//   slave  : the controller itself
// Parameters SEL_W and CREDIT_W must match the controller instance.
// ---------------------------------------------------------------------------
interface vending_machine_multi_if #(
    parameter int SEL_W    = 2,
    parameter int CREDIT_W = 6
);
    localparam int N_ITEMS = 1 << SEL_W;

    logic [1:0]          coin;
    logic [SEL_W-1:0]    sel;
    logic                vend_req;
    logic                cancel;
    logic                restock;
    logic                out;
    logic [SEL_W-1:0]    out_item;
    logic                change_5;
    logic                coin_reject;
    logic                vend_fail;
    logic [CREDIT_W-1:0] credit;
    logic [N_ITEMS-1:0]  sold_out;
    logic [1:0]          state;

    modport master (
        output coin, sel, vend_req, cancel, restock,
        input  out, out_item, change_5, coin_reject, vend_fail, credit, sold_out, state
    );

    modport slave (
        input  coin, sel, vend_req, cancel, restock,
        output out, out_item, change_5, coin_reject, vend_fail, credit, sold_out, state
    );
endinterface

// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
// Multi-product vending controller. Accepts 5/10-unit coins into a
// saturating credit register, vends one of 2^SEL_W products with per-slot
// stock counters, and pays change back one 5-unit coin per cycle.
// Ports:
//   clk  : single clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : slave side of vending_machine_multi_if
//          (coin/sel/vend_req/cancel/restock in;
//           out/out_item/change_5/coin_reject/vend_fail/credit/sold_out/state out)
// ---------------------------------------------------------------------------
module vending_machine_multi #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 30,
    parameter int CREDIT_W   = 6,
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    vending_machine_multi_if.slave bus
);
    localparam int N_ITEMS = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        REFUND  = 2'b11
    } state_t;

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [SEL_W-1:0]    out_item_reg, out_item_next;
    logic                coin_reject_reg, coin_reject_next;
    logic                vend_fail_reg, vend_fail_next;
    logic                vend_take;

    logic [N_ITEMS*STOCK_W-1:0] stock_flat;
    logic [N_ITEMS-1:0]         sold_out_flat;

    // Coin decode; the extra credit_sum bit lets the ceiling test see overflow.
    logic                coin_valid;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic                stock_avail;

    always_comb begin
        coin_valid = 1'b0;
        coin_val   = '0;
        case (bus.coin)
            2'b01: begin
                coin_valid = 1'b1;
                coin_val   = (CREDIT_W+1)'(5);
            end
            2'b10: begin
                coin_valid = 1'b1;
                coin_val   = (CREDIT_W+1)'(10);
            end
            default: begin
                coin_valid = 1'b0;
                coin_val   = '0;
            end
        endcase
    end

    assign credit_sum  = {1'b0, credit_reg} + coin_val;
    assign stock_avail = (stock_flat[bus.sel*STOCK_W +: STOCK_W] != '0);

    // Next-state / datapath. Priority inside COLLECT: cancel > vend > coin.
    always_comb begin
        state_next       = state_reg;
        credit_next      = credit_reg;
        out_item_next    = out_item_reg;
        coin_reject_next = 1'b0;
        vend_fail_next   = 1'b0;
        vend_take        = 1'b0;

        case (state_reg)
            IDLE, COLLECT: begin
                if (state_reg == COLLECT && bus.cancel) begin
                    state_next       = REFUND;
                    coin_reject_next = coin_valid;
                end else if (state_reg == COLLECT && bus.vend_req &&
                             credit_reg >= CREDIT_W'(PRICE) && stock_avail) begin
                    state_next       = VEND;
                    credit_next      = credit_reg - CREDIT_W'(PRICE);
                    out_item_next    = bus.sel;
                    vend_take        = 1'b1;
                    coin_reject_next = coin_valid;
                end else begin
                    // Refused (or absent) vend: the coin is still processed.
                    vend_fail_next = bus.vend_req;
                    if (coin_valid) begin
                        if (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                            credit_next = credit_sum[CREDIT_W-1:0];
                            state_next  = COLLECT;
                        end else begin
                            coin_reject_next = 1'b1;
                        end
                    end
                end
            end
            VEND: begin
                coin_reject_next = coin_valid;
                state_next       = (credit_reg != '0) ? REFUND : IDLE;
            end
            REFUND: begin
                coin_reject_next = coin_valid;
                // Guarded against underflow in case credit is ever below 5.
                if (credit_reg <= CREDIT_W'(5)) begin
                    credit_next = '0;
                    state_next  = IDLE;
                end else begin
                    credit_next = credit_reg - CREDIT_W'(5);
                end
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            credit_reg      <= '0;
            out_item_reg    <= '0;
            coin_reject_reg <= 1'b0;
            vend_fail_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            credit_reg      <= credit_next;
            out_item_reg    <= out_item_next;
            coin_reject_reg <= coin_reject_next;
            vend_fail_reg   <= vend_fail_next;
        end
    end

    // Per-slot stock counter; restock wins over a same-cycle vend decrement.
    // sold_out is registered from the post-edge stock value.
    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_slot
        logic [STOCK_W-1:0] stock_reg, stock_next;
        logic               sold_out_reg;

        always_comb begin
            stock_next = stock_reg;
            if (bus.restock) begin
                stock_next = STOCK_W'(STOCK_INIT);
            end else if (vend_take && bus.sel == SEL_W'(gi) && stock_reg != '0) begin
                stock_next = stock_reg - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stock_reg    <= STOCK_W'(STOCK_INIT);
                sold_out_reg <= (STOCK_INIT == 0);
            end else begin
                stock_reg    <= stock_next;
                sold_out_reg <= (stock_next == '0);
            end
        end

        assign stock_flat[gi*STOCK_W +: STOCK_W] = stock_reg;
        assign sold_out_flat[gi]                 = sold_out_reg;
    end

    assign bus.out         = (state_reg == VEND);
    assign bus.change_5    = (state_reg == REFUND);
    assign bus.out_item    = out_item_reg;
    assign bus.coin_reject = coin_reject_reg;
    assign bus.vend_fail   = vend_fail_reg;
    assign bus.credit      = credit_reg;
    assign bus.sold_out    = sold_out_flat;
    assign bus.state       = state_reg;
endmodule

// File: tb/tb_vending_machine_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_multi
// Drives vending_machine_multi through the directed scenarios of the test
// plan followed by randomized traffic, comparing every output each cycle
// against a behavioural model held in plain integers.
// ---------------------------------------------------------------------------
module tb_vending_machine_multi;
    localparam int PRICE      = 15;
    localparam int MAX_CREDIT = 30;
    localparam int CREDIT_W   = 6;
    localparam int SEL_W      = 2;
    localparam int STOCK_W    = 4;
    localparam int STOCK_INIT = 4;
    localparam int N_ITEMS    = 1 << SEL_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vending_machine_multi_if #(.SEL_W(SEL_W), .CREDIT_W(CREDIT_W)) bus ();

    vending_machine_multi #(
        .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W),
        .SEL_W(SEL_W), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: money and stock as plain integers.
    int m_state;      // 0 idle, 1 collect, 2 vend, 3 refund
    int m_credit;
    int m_item;
    int m_reject;
    int m_fail;
    int m_stock [N_ITEMS];
    int cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL cyc=%0d %s got=%0d exp=%0d", cyc, tag, got, exp);
        end
    endtask

    function automatic int coin_units(input logic [1:0] c);
        if (c == 2'b01) return 5;
        if (c == 2'b10) return 10;
        return 0;
    endfunction

    // Apply the rules for one clock edge to the model.
    task automatic model_edge(input logic [1:0] c, input int s, input bit v,
                              input bit cn, input bit rs, input bit r);
        int units;
        units    = coin_units(c);
        m_reject = 0;
        m_fail   = 0;
        if (r) begin
            m_state  = 0;
            m_credit = 0;
            m_item   = 0;
            foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
            return;
        end
        if (m_state == 2) begin
            m_reject = (units != 0);
            m_state  = (m_credit > 0) ? 3 : 0;
        end else if (m_state == 3) begin
            m_reject = (units != 0);
            m_credit = m_credit - 5;
            if (m_credit == 0) m_state = 0;
        end else if (m_state == 1 && cn) begin
            m_reject = (units != 0);
            m_state  = 3;
        end else if (m_state == 1 && v && m_credit >= PRICE && m_stock[s] > 0) begin
            m_reject   = (units != 0);
            m_credit   = m_credit - PRICE;
            m_stock[s] = m_stock[s] - 1;
            m_item     = s;
            m_state    = 2;
        end else begin
            m_fail = v;
            if (units != 0) begin
                if (m_credit + units <= MAX_CREDIT) begin
                    m_credit = m_credit + units;
                    m_state  = 1;
                end else begin
                    m_reject = 1;
                end
            end
        end
        if (rs) foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
    endtask

    task automatic check_outputs();
        int exp_sold;
        exp_sold = 0;
        for (int i = 0; i < N_ITEMS; i++)
            if (m_stock[i] == 0) exp_sold |= (1 << i);
        check("state",       int'(bus.state),       m_state);
        check("credit",      int'(bus.credit),      m_credit);
        check("out",         int'(bus.out),         int'(m_state == 2));
        check("change_5",    int'(bus.change_5),    int'(m_state == 3));
        check("coin_reject", int'(bus.coin_reject), m_reject);
        check("vend_fail",   int'(bus.vend_fail),   m_fail);
        check("sold_out",    int'(bus.sold_out),    exp_sold);
        if (m_state == 2) check("out_item", int'(bus.out_item), m_item);
    endtask

    // One transaction: drive inputs, advance one edge, compare after it.
    task automatic step(input logic [1:0] c, input int s, input bit v,
                        input bit cn, input bit rs, input bit r);
        bus.coin     = c;
        bus.sel      = SEL_W'(s);
        bus.vend_req = v;
        bus.cancel   = cn;
        bus.restock  = rs;
        rst          = r;
        model_edge(c, s, v, cn, rs, r);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        $display("[TB] cyc=%0d rst=%0d coin=%0d sel=%0d vend=%0d cancel=%0d restock=%0d -> state=%0d credit=%0d out=%0d item=%0d chg=%0d rej=%0d fail=%0d sold=%b",
                 cyc, r, c, s, v, cn, rs, bus.state, bus.credit, bus.out,
                 bus.out_item, bus.change_5, bus.coin_reject, bus.vend_fail, bus.sold_out);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int units);
        step((units == 10) ? 2'b10 : 2'b01, 0, 0, 0, 0, 0);
    endtask

    task automatic vend(input int s);
        step(2'b00, s, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(2'b00, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.coin = 2'b00; bus.sel = '0; bus.vend_req = 1'b0;
        bus.cancel = 1'b0; bus.restock = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        do_reset();

        // Exact price, no change
        coin(10); coin(5); vend(2); idle(2);

        // Overpay, one change coin
        coin(10); coin(10); vend(0); idle(3);

        // Ceiling: fourth coin rejected, then a 6-coin refund
        coin(10); coin(10); coin(10); coin(5);
        step(2'b00, 0, 0, 1, 0, 0);
        idle(7);

        // Drain slot 1, refused vend keeps credit, restock revives it
        for (int k = 0; k < STOCK_INIT; k++) begin
            coin(10); coin(5); vend(1); idle(1);
        end
        coin(10); coin(5); vend(1);
        step(2'b00, 0, 0, 0, 1, 0);
        vend(1); idle(2);

        // Insufficient credit, then coin together with cancel
        coin(10); vend(3);
        step(2'b01, 0, 0, 1, 0, 0);
        idle(3);

        // Vend request while idle, invalid coin code ignored
        vend(0); step(2'b11, 0, 0, 0, 0, 0); idle(1);

        // Reset during the third refund cycle
        coin(10); coin(10); vend(0); idle(1);
        coin(10); coin(10); coin(10);
        step(2'b00, 0, 0, 1, 0, 0);
        idle(2);
        do_reset();
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] c;
            int  s;
            bit  v, cn, rs, r;
            c  = 2'($urandom_range(0, 3));
            s  = int'($urandom_range(0, N_ITEMS - 1));
            v  = ($urandom_range(0, 99) < 30);
            cn = ($urandom_range(0, 99) < 6);
            rs = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 199) == 0);
            step(c, s, v, cn, rs, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
